cga_bridge: RTL

CPU-side port controller for the 8 KiB CGA text/video memory (8192 × 8, 13-bit address). It sits upstream of the memory's second port, opposite the CGA scanner, which reads the first port at 25 MHz. It buffers CPU writes in a small FIFO and serves CPU reads with a fixed-latency handshake. An optional engine fills the 80×25 text screen with a character/attribute pair.

---
 rtl/cga_pkg.sv | 15 +
 rtl/cga_bridge_fifo.sv | 41 ++++
 rtl/cga_bridge.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cga_pkg.sv
// Shared widths, sizes and FSM state encoding for the CGA CPU-side memory bridge.
package cga_pkg;

  localparam int CGA_ADDR_W     = 13;
  localparam int CGA_DATA_W     = 8;
  localparam int CGA_TEXT_BYTES = 4000;
  localparam int CGA_FIFO_W     = CGA_ADDR_W + CGA_DATA_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RDWAIT = 2'd1,
    CLEAR  = 2'd2
  } cga_state_e;

endpackage

// File: rtl/cga_bridge_fifo.sv
// Write-buffer FIFO for the CGA bridge: {address, data} entries, show-ahead read port.
module cga_bridge_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) store[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = store[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/cga_bridge.sv
// CPU-side controller for port B of the CGA text memory: buffered writes, fixed-latency reads,
// and an optional screen-fill engine enabled by the CGA_BRIDGE_CLEAR_EN macro.
module cga_bridge
  import cga_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int MEM_LATENCY = 2,
  parameter int CLEAR_BYTES = CGA_TEXT_BYTES
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [CGA_ADDR_W-1:0] cpu_address,
  input  logic [CGA_DATA_W-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic [CGA_DATA_W-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  clr_start,
  input  logic [CGA_DATA_W-1:0] clr_char,
  input  logic [CGA_DATA_W-1:0] clr_attr,
  output logic                  clr_busy,
  output logic [CGA_ADDR_W-1:0] mem_address,
  output logic [CGA_DATA_W-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [CGA_DATA_W-1:0] mem_q,
  output cga_state_e            dbg_state
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  cga_state_e             state;
  logic                   run;
  logic [LAT_W-1:0]       rd_cnt;
  logic                   pending;
  logic                   wr_ok, rd_ok, push, pop, rd_take;
  logic                   fifo_full, fifo_empty;
  logic [CGA_FIFO_W-1:0]  fifo_head;

`ifdef CGA_BRIDGE_CLEAR_EN
  localparam int CNT_W = CGA_ADDR_W + 1;
  logic [CNT_W-1:0]      clr_cnt;
  logic [CGA_DATA_W-1:0] fill_char, fill_attr;
`else
  logic unused_clr;
  assign unused_clr = ^{clr_start, clr_char, clr_attr};
  assign pending    = 1'b0;
`endif

  // Handshake: a request transfers on a clock edge where cpu_req && cpu_ready; cpu_ready depends
  // combinationally on cpu_we and is never high while in reset or during the first cycle after it.
  assign wr_ok     = run && !fifo_full && (state != CLEAR) && !pending;
  assign rd_ok     = run && (state == IDLE) && fifo_empty && !mem_wren && !pending;
  assign cpu_ready = cpu_we ? wr_ok : rd_ok;
  assign push      = cpu_req && cpu_we && wr_ok;
  assign rd_take   = cpu_req && !cpu_we && rd_ok;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign clr_busy  = pending;
  assign dbg_state = state;

  cga_bridge_fifo #(.WIDTH(CGA_FIFO_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({cpu_address, cpu_wdata}),
    .pop     (pop),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      run         <= 1'b0;
      rd_cnt      <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      cpu_rdata   <= '0;
      cpu_rvalid  <= 1'b0;
`ifdef CGA_BRIDGE_CLEAR_EN
      pending     <= 1'b0;
      clr_cnt     <= '0;
      fill_char   <= '0;
      fill_attr   <= '0;
`endif
    end else begin
      run        <= 1'b1;
      mem_wren   <= 1'b0;
      cpu_rvalid <= 1'b0;
`ifdef CGA_BRIDGE_CLEAR_EN
      if (clr_start && state != CLEAR) pending <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (rd_take) begin
            state       <= RDWAIT;
            mem_address <= cpu_address;
            rd_cnt      <= LAT_W'(MEM_LATENCY - 1);
          end else if (pop) begin
            mem_address <= fifo_head[CGA_FIFO_W-1:CGA_DATA_W];
            mem_data    <= fifo_head[CGA_DATA_W-1:0];
            mem_wren    <= 1'b1;
          end
`ifdef CGA_BRIDGE_CLEAR_EN
          else if (pending) begin
            // Byte 0 goes out on the entry edge so the fill runs exactly CLEAR_BYTES cycles.
            state       <= CLEAR;
            mem_address <= '0;
            mem_data    <= clr_char;
            mem_wren    <= 1'b1;
            clr_cnt     <= CNT_W'(1);
            fill_char   <= clr_char;
            fill_attr   <= clr_attr;
          end
`endif
        end
        RDWAIT: begin
          if (rd_cnt == '0) begin
            cpu_rdata  <= mem_q;
            cpu_rvalid <= 1'b1;
            state      <= IDLE;
          end else begin
            rd_cnt <= rd_cnt - LAT_W'(1);
          end
        end
`ifdef CGA_BRIDGE_CLEAR_EN
        CLEAR: begin
          if (clr_cnt == CNT_W'(CLEAR_BYTES)) begin
            state   <= IDLE;
            pending <= 1'b0;
          end else begin
            mem_address <= clr_cnt[CGA_ADDR_W-1:0];
            mem_data    <= clr_cnt[0] ? fill_attr : fill_char;
            mem_wren    <= 1'b1;
            clr_cnt     <= clr_cnt + CNT_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
